// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
// Holds the bridge state encoding, the AHB transfer-type and response
// encodings, and the address-window test shared by the bridge and its bench.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // True when addr falls inside the power-of-two window starting at base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return ((addr & ~(size - 32'd1)) == base);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_timeout.sv
// ACCESS-phase watchdog for the AHB-APB bridge.
// Only compiled when AHB_APB_BRIDGE_TIMEOUT_EN is defined; the default
// build has no watchdog and this file contributes nothing.
// The count clears while the bridge sits in SETUP and advances once per
// enabled ACCESS cycle in which the completer is not ready. It saturates at
// TimeoutCycles, at which point expired stays high until the next SETUP.
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
module apb_timeout #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] count;

    assign expired = (count == CntW'(TimeoutCycles));

    // Wait-cycle counter, held while the clock enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clk_en) begin
            if (clear) begin
                count <= '0;
            end else if (inc && !expired) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge.
// Each single AHB transfer inside [BaseAddr, BaseAddr+WindowSize) becomes
// one APB SETUP/ACCESS pair; AHB wait states are inserted until the APB
// completer answers. Out-of-window transfers get a two-cycle AHB ERROR and
// never reach APB. All state advances only on enabled h_clk edges.
// Optional feature: define AHB_APB_BRIDGE_TIMEOUT_EN to add an ACCESS
// watchdog that turns a completer stuck at p_ready=0 into an AHB ERROR
// after TimeoutCycles enabled wait cycles.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BaseAddr      = 32'h4000_0000,
    parameter logic [31:0] WindowSize    = 32'h0000_1000,
    parameter int          TimeoutCycles = 16
) (
    input  logic        h_clk,
    input  logic        h_reset_n,
    input  logic        h_clk_en,
    input  logic        h_sel,
    input  logic [31:0] h_addr,
    input  logic [1:0]  h_trans,
    input  logic [2:0]  h_size,
    input  logic        h_write,
    input  logic [31:0] h_wdata,
    input  logic [3:0]  h_wstrb,
    input  logic        h_ready,
    output logic        h_readyout,
    output logic        h_resp,
    output logic [31:0] h_rdata,
    output logic        p_sel,
    output logic        p_enable,
    output logic [31:0] p_addr,
    output logic        p_write,
    output logic [31:0] p_wdata,
    output logic [3:0]  p_strb,
    input  logic        p_ready,
    input  logic [31:0] p_rdata,
    input  logic        p_slverr
);

    // Elaboration-time sanity checks on the configuration.
    if ((BaseAddr & 32'h0000_0FFF) != 32'd0) begin : g_bad_base
        $error("BaseAddr must be 4 KiB aligned");
    end
    if ((WindowSize == 32'd0) || ((WindowSize & (WindowSize - 32'd1)) != 32'd0)) begin : g_bad_size
        $error("WindowSize must be a non-zero power of two");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    bridge_state_e state_q;
    bridge_state_e state_d;

    logic accept;      // valid AHB address phase this enabled cycle
    logic addr_hit;    // that address lies inside the APB window
    logic open_slot;   // current cycle may take a new address phase
    logic load_addr;   // capture address/direction for a new APB access
    logic timed_out;   // watchdog fired during ACCESS
    logic data_phase;  // APB SETUP or ACCESS in progress

    // Transfer size is always treated as word and BUSY is never accepted,
    // so these bits carry no information for the bridge.
    logic unused_inputs;
    assign unused_inputs = ^{h_size, h_trans[0]};

    assign accept   = h_sel & h_trans[1] & h_ready & h_clk_en;
    assign addr_hit = in_window(h_addr, BaseAddr, WindowSize);

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
    apb_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk     (h_clk),
        .rst_n   (h_reset_n),
        .clk_en  (h_clk_en),
        .clear   (state_q == ST_SETUP),
        .inc     ((state_q == ST_ACCESS) && !p_ready),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // State register; holds whenever the clock enable is low.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge h_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state_q <= ST_IDLE;
        end else if (h_clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state decode and bus handshake outputs.
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        open_slot  = 1'b0;
        load_addr  = 1'b0;
        h_readyout = 1'b1;
        h_resp     = HRESP_OKAY;
        h_rdata    = '0;
        p_sel      = 1'b0;
        p_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                open_slot = 1'b1;
            end

            ST_SETUP: begin
                p_sel      = 1'b1;
                h_readyout = 1'b0;
                state_d    = ST_ACCESS;
            end

            ST_ACCESS: begin
                p_sel      = 1'b1;
                p_enable   = 1'b1;
                h_readyout = 1'b0;
                if (timed_out) begin
                    // Abandon the APB access; a late p_ready is ignored.
                    p_sel    = 1'b0;
                    p_enable = 1'b0;
                    h_resp   = HRESP_ERROR;
                    state_d  = ST_ERR2;
                end else if (p_ready) begin
                    if (p_slverr) begin
                        h_resp  = HRESP_ERROR;
                        state_d = ST_ERR2;
                    end else begin
                        h_readyout = 1'b1;
                        if (!p_write) begin
                            h_rdata = p_rdata;
                        end
                        state_d   = ST_IDLE;
                        open_slot = 1'b1;
                    end
                end
            end

            ST_ERR1: begin
                h_readyout = 1'b0;
                h_resp     = HRESP_ERROR;
                state_d    = ST_ERR2;
            end

            ST_ERR2: begin
                h_resp    = HRESP_ERROR;
                state_d   = ST_IDLE;
                open_slot = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new address phase overrides the idle return, giving
        // back-to-back accesses without a gap.
        if (open_slot && accept) begin
            if (addr_hit) begin
                state_d   = ST_SETUP;
                load_addr = 1'b1;
            end else begin
                state_d = ST_ERR1;
            end
        end
    end

    // APB address and direction, captured at address-phase accept and held
    // between transfers.
    always_ff @(posedge h_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            p_addr  <= '0;
            p_write <= 1'b0;
        end else if (load_addr) begin
            p_addr  <= {h_addr[31:2], 2'b00};
            p_write <= h_write;
        end
    end

    // Write data passes straight through; AHB holds it stable while the
    // bridge stalls, so no data register is needed.
    assign data_phase = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign p_wdata    = (data_phase && p_write) ? h_wdata : '0;
    assign p_strb     = (data_phase && p_write) ? h_wstrb : '0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge.
// Inputs change on the falling edge; outputs are checked 1 ns later, well
// away from the rising edge the bridge uses.
// Covers both builds: the stuck-completer case expects an ERROR with
// AHB_APB_BRIDGE_TIMEOUT_EN defined and an indefinite wait without it.
module tb_ahb_apb_bridge;
    import ahb_apb_pkg::*;

    logic        h_clk = 1'b0;
    logic        h_reset_n;
    logic        h_clk_en;
    logic        h_sel;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic [2:0]  h_size;
    logic        h_write;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic        h_ready;
    logic        h_readyout;
    logic        h_resp;
    logic [31:0] h_rdata;
    logic        p_sel;
    logic        p_enable;
    logic [31:0] p_addr;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        p_slverr;

    int errors = 0;
    int checks = 0;

    // Single slave on the bus: HREADY is this slave's HREADYOUT.
    assign h_ready = h_readyout;

    always #5 h_clk = ~h_clk;

    ahb_apb_bridge #(
        .BaseAddr      (32'h4000_0000),
        .WindowSize    (32'h0000_1000),
        .TimeoutCycles (16)
    ) dut (
        .h_clk      (h_clk),
        .h_reset_n  (h_reset_n),
        .h_clk_en   (h_clk_en),
        .h_sel      (h_sel),
        .h_addr     (h_addr),
        .h_trans    (h_trans),
        .h_size     (h_size),
        .h_write    (h_write),
        .h_wdata    (h_wdata),
        .h_wstrb    (h_wstrb),
        .h_ready    (h_ready),
        .h_readyout (h_readyout),
        .h_resp     (h_resp),
        .h_rdata    (h_rdata),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_addr     (p_addr),
        .p_write    (p_write),
        .p_wdata    (p_wdata),
        .p_strb     (p_strb),
        .p_ready    (p_ready),
        .p_rdata    (p_rdata),
        .p_slverr   (p_slverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge h_clk);
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic write);
        h_sel   = 1'b1;
        h_trans = HTRANS_NONSEQ;
        h_addr  = addr;
        h_write = write;
    endtask

    task automatic bus_idle();
        h_sel   = 1'b0;
        h_trans = HTRANS_IDLE;
        h_addr  = '0;
        h_write = 1'b0;
    endtask

    // Handshake outputs bundled as {p_sel, p_enable, h_readyout, h_resp}.
    function automatic logic [31:0] hs();
        return {28'd0, p_sel, p_enable, h_readyout, h_resp};
    endfunction

    initial begin
        int waits;
        int stalled;

        h_reset_n = 1'b1;
        h_clk_en  = 1'b1;
        h_size    = 3'b010;
        h_wdata   = '0;
        h_wstrb   = '0;
        p_ready   = 1'b0;
        p_rdata   = '0;
        p_slverr  = 1'b0;
        bus_idle();

        // ---------------- reset ----------------
        #2 h_reset_n = 1'b0;
        #1;
        check("rst_hs", hs(), 32'b0010);
        check("rst_h_rdata", h_rdata, 32'h0);
        check("rst_p_addr", p_addr, 32'h0);
        check("rst_p_write", {31'd0, p_write}, 32'h0);
        check("rst_p_wdata", p_wdata, 32'h0);
        check("rst_p_strb", {28'd0, p_strb}, 32'h0);
        repeat (2) tick();
        h_reset_n = 1'b1;
        #1;
        check("idle_hs", hs(), 32'b0010);

        // ---------------- write, zero APB wait states ----------------
        tick();
        addr_phase(32'h4000_0010, 1'b1);
        #1;
        check("wr_addr_ready", hs(), 32'b0010);
        tick();                                   // SETUP
        bus_idle();
        h_wdata = 32'hDEAD_BEEF;
        h_wstrb = 4'b0101;
        #1;
        check("wr_setup_hs", hs(), 32'b1000);
        check("wr_setup_addr", p_addr, 32'h4000_0010);
        check("wr_setup_write", {31'd0, p_write}, 32'h1);
        check("wr_setup_wdata", p_wdata, 32'hDEAD_BEEF);
        check("wr_setup_strb", {28'd0, p_strb}, 32'h5);
        tick();                                   // ACCESS, completes
        p_ready = 1'b1;
        addr_phase(32'h4000_0FFC, 1'b0);          // back-to-back read
        #1;
        check("wr_access_hs", hs(), 32'b1110);
        check("wr_access_wdata", p_wdata, 32'hDEAD_BEEF);
        check("wr_access_strb", {28'd0, p_strb}, 32'h5);

        // ---------------- read with 3 APB wait states ----------------
        waits = 0;
        tick();                                   // SETUP, no IDLE gap
        bus_idle();
        h_wdata = '0;
        h_wstrb = '0;
        p_ready = 1'b0;
        p_rdata = 32'h1234_5678;
        #1;
        if (!h_readyout) waits++;
        check("rd_setup_hs", hs(), 32'b1000);
        check("rd_setup_addr", p_addr, 32'h4000_0FFC);
        check("rd_setup_write", {31'd0, p_write}, 32'h0);
        check("rd_setup_strb", {28'd0, p_strb}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            if (!h_readyout) waits++;
            check("rd_wait_hs", hs(), 32'b1100);
            check("rd_wait_rdata", h_rdata, 32'h0);
        end
        tick();
        p_ready = 1'b1;
        #1;
        if (!h_readyout) waits++;
        check("rd_done_hs", hs(), 32'b1110);
        check("rd_done_rdata", h_rdata, 32'h1234_5678);
        check("rd_wait_states", waits, 32'd4);
        tick();
        p_ready = 1'b0;
        p_rdata = '0;
        #1;
        check("rd_idle_hs", hs(), 32'b0010);
        check("rd_idle_rdata", h_rdata, 32'h0);
        check("rd_addr_held", p_addr, 32'h4000_0FFC);

        // ---------------- out-of-window reads ----------------
        tick();
        addr_phase(32'h4000_1000, 1'b0);
        #1;
        tick();                                   // ERR1
        bus_idle();
        #1;
        check("oow_hi_err1", hs(), 32'b0001);
        tick();                                   // ERR2, next transfer accepted
        addr_phase(32'h3FFF_FFFC, 1'b0);
        #1;
        check("oow_hi_err2", hs(), 32'b0011);
        tick();
        bus_idle();
        #1;
        check("oow_lo_err1", hs(), 32'b0001);
        tick();
        #1;
        check("oow_lo_err2", hs(), 32'b0011);
        tick();
        #1;
        check("oow_idle", hs(), 32'b0010);
        check("oow_addr_untouched", p_addr, 32'h4000_0FFC);

        // ---------------- slave error, then read accepted in ERR2 ----------------
        tick();
        addr_phase(32'h4000_0000, 1'b1);
        #1;
        tick();                                   // SETUP
        bus_idle();
        h_wdata = 32'h55AA_55AA;
        h_wstrb = 4'hF;
        #1;
        check("slv_setup_addr", p_addr, 32'h4000_0000);
        tick();                                   // ACCESS with error
        p_ready  = 1'b1;
        p_slverr = 1'b1;
        #1;
        check("slv_err1_hs", hs(), 32'b1101);
        tick();                                   // ERR2
        p_ready  = 1'b0;
        p_slverr = 1'b0;
        h_wdata  = '0;
        h_wstrb  = '0;
        addr_phase(32'h4000_0100, 1'b0);
        #1;
        check("slv_err2_hs", hs(), 32'b0011);
        tick();                                   // SETUP of the read
        bus_idle();
        #1;
        check("slv_rd_setup_hs", hs(), 32'b1000);
        check("slv_rd_addr", p_addr, 32'h4000_0100);
        tick();
        p_ready = 1'b1;
        p_rdata = 32'hCAFE_F00D;
        #1;
        check("slv_rd_done_hs", hs(), 32'b1110);
        check("slv_rd_rdata", h_rdata, 32'hCAFE_F00D);
        tick();
        p_ready = 1'b0;
        p_rdata = '0;
        #1;
        check("slv_idle_hs", hs(), 32'b0010);

        // ---------------- clock enable hold, then reset mid-transfer ----------------
        tick();
        addr_phase(32'h4000_0020, 1'b1);
        #1;
        tick();                                   // SETUP
        bus_idle();
        h_wdata  = 32'h0BAD_F00D;
        h_wstrb  = 4'b0011;
        h_clk_en = 1'b0;
        #1;
        check("ce_setup_hs", hs(), 32'b1000);
        tick();
        #1;
        check("ce_hold1_hs", hs(), 32'b1000);
        tick();
        h_clk_en = 1'b1;
        #1;
        check("ce_hold2_hs", hs(), 32'b1000);
        tick();                                   // ACCESS
        #1;
        check("ce_access_hs", hs(), 32'b1100);
        h_reset_n = 1'b0;
        #1;
        check("mid_rst_hs", hs(), 32'b0010);
        check("mid_rst_addr", p_addr, 32'h0);
        check("mid_rst_wdata", p_wdata, 32'h0);
        tick();
        h_reset_n = 1'b1;
        h_wdata   = '0;
        h_wstrb   = '0;

        // ---------------- completer stuck at p_ready=0 ----------------
        tick();
        addr_phase(32'h4000_0040, 1'b0);
        #1;
        tick();                                   // SETUP
        bus_idle();
        #1;
        check("stuck_setup_hs", hs(), 32'b1000);
        stalled = 0;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            tick();
            #1;
            if (p_sel && p_enable && !h_readyout && !h_resp) stalled++;
        end
        check("to_wait_cycles", stalled, 32'd16);
        tick();                                   // watchdog fires
        p_ready = 1'b1;                           // late, must be ignored
        #1;
        check("to_fire_hs", hs(), 32'b0001);
        tick();
        p_ready = 1'b0;
        #1;
        check("to_err2_hs", hs(), 32'b0011);
        tick();
        #1;
        check("to_idle_hs", hs(), 32'b0010);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            #1;
            if (p_sel && p_enable && !h_readyout && !h_resp) stalled++;
        end
        check("nto_wait_cycles", stalled, 32'd100);
        tick();
        p_ready = 1'b1;
        p_rdata = 32'hA5A5_0001;
        #1;
        check("nto_done_hs", hs(), 32'b1110);
        check("nto_done_rdata", h_rdata, 32'hA5A5_0001);
        tick();
        p_ready = 1'b0;
        p_rdata = '0;
        #1;
        check("nto_idle_hs", hs(), 32'b0010);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
